// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl_pkg
// Description : Shared types and constants for the pipeline hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_ctrl_pkg;

    // Sequencer states of the hazard controller
    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2,
        HALT       = 2'd3
    } hz_state_t;

    // Architectural zero register: reads of it never create a dependency
    localparam logic [4:0] REG_X0 = 5'd0;

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl_if
// Description : Hazard-control bundle between the 5-stage pipeline (master)
//               and the hazard controller (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_ctrl_if;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_rs1_en;
    logic        id_rs2_en;
    logic [4:0]  idex_rd;
    logic        idex_memRead;
    logic        ex_redirect;
    logic        mem_req;
    logic        mem_ack;
    logic        pc_en;
    logic        ifid_en;
    logic        ifid_flush;
    logic        idex_en;
    logic        idex_flush;
    logic        exmem_en;
    logic        memwb_bubble;
    logic        mem_fault;
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;

    modport master (
        output id_rs1, id_rs2, id_rs1_en, id_rs2_en, idex_rd, idex_memRead,
               ex_redirect, mem_req, mem_ack,
        input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
               memwb_bubble, mem_fault, stall_cycles, flush_count
    );

    modport slave (
        input  id_rs1, id_rs2, id_rs1_en, id_rs2_en, idex_rd, idex_memRead,
               ex_redirect, mem_req, mem_ack,
        output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
               memwb_bubble, mem_fault, stall_cycles, flush_count
    );
endinterface
`default_nettype wire

// File: rtl/hazard_perf_cnt.sv
`default_nettype none
// ============================================================================
// Module      : hazard_perf_cnt
// Description : Stall-cycle and flush performance counters (32-bit, wrapping).
//               Only compiled when HAZARD_CTRL_PERF_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`ifdef HAZARD_CTRL_PERF_CNT_EN
module hazard_perf_cnt (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        stall_inc,
    input  wire logic        flush_inc,
    output logic [31:0]      stall_cycles,
    output logic [31:0]      flush_count
);
    logic [31:0] stall_q, stall_d;
    logic [31:0] flush_q, flush_d;

    // Next counter values; natural 32-bit wrap
    always_comb begin
        stall_d = stall_q + {31'd0, stall_inc};
        flush_d = flush_q + {31'd0, flush_inc};
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
endmodule
`endif
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline sequencing controller for the 5-stage core: load-use
//               bubbles, EX redirect flush, data-memory wait with timeout.
//               Optional perf counters: HAZARD_CTRL_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int LOAD_BUBBLES = 1,
    parameter int MEM_TIMEOUT  = 256,
    parameter int TO_W         = $clog2(MEM_TIMEOUT + 1)
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    hazard_ctrl_if.slave hz
);
    hz_state_t       state_q, state_d;
    hz_state_t       ret_q, ret_d;
    hz_state_t       eff_state;
    logic [3:0]      bcnt_q, bcnt_d;
    logic [TO_W-1:0] tocnt_q, tocnt_d;

    logic load_use;
    logic mwait;
    logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_bubble;

    assign load_use = hz.idex_memRead && (hz.idex_rd != REG_X0) &&
                      ((hz.id_rs1_en && (hz.id_rs1 == hz.idex_rd)) ||
                       (hz.id_rs2_en && (hz.id_rs2 == hz.idex_rd)));
    assign mwait    = hz.mem_req && !hz.mem_ack;

    // Next state and control outputs; priority mwait > redirect > load stall
    always_comb begin
        state_d      = state_q;
        ret_d        = ret_q;
        bcnt_d       = bcnt_q;
        tocnt_d      = '0;
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        ifid_flush   = 1'b0;
        idex_en      = 1'b1;
        idex_flush   = 1'b0;
        exmem_en     = 1'b1;
        memwb_bubble = 1'b0;
        // On the completing cycle of a wait, act as the state we return to
        eff_state    = (state_q == MEM_WAIT) ? ret_q : state_q;

        if (state_q == HALT) begin
            pc_en = 1'b0; ifid_en = 1'b0; idex_en = 1'b0; exmem_en = 1'b0;
            memwb_bubble = 1'b1;
        end else if (mwait) begin
            pc_en = 1'b0; ifid_en = 1'b0; idex_en = 1'b0; exmem_en = 1'b0;
            memwb_bubble = 1'b1;
            if (state_q == MEM_WAIT) begin
                tocnt_d = tocnt_q + 1'b1;
                if (tocnt_d == TO_W'(MEM_TIMEOUT)) begin
                    state_d = HALT;
                end
            end else begin
                // First wait cycle counts as one; bubble count is preserved
                state_d = MEM_WAIT;
                ret_d   = state_q;
                tocnt_d = TO_W'(1);
            end
        end else if (hz.ex_redirect) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            state_d    = RUN;
            bcnt_d     = 4'd0;
        end else if ((eff_state == LOAD_STALL) || load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
            if (eff_state == LOAD_STALL) begin
                if (bcnt_q <= 4'd1) begin
                    state_d = RUN;
                    bcnt_d  = 4'd0;
                end else begin
                    state_d = LOAD_STALL;
                    bcnt_d  = bcnt_q - 4'd1;
                end
            end else if (LOAD_BUBBLES > 1) begin
                state_d = LOAD_STALL;
                bcnt_d  = 4'(LOAD_BUBBLES - 1);
            end else begin
                state_d = RUN;
            end
        end else begin
            state_d = RUN;
        end

        // While reset is held the pipeline sees plain defaults
        if (!rst_n) begin
            pc_en = 1'b1; ifid_en = 1'b1; idex_en = 1'b1; exmem_en = 1'b1;
            ifid_flush = 1'b0; idex_flush = 1'b0; memwb_bubble = 1'b0;
        end
    end

    // State, return-state and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            ret_q   <= RUN;
            bcnt_q  <= 4'd0;
            tocnt_q <= '0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            bcnt_q  <= bcnt_d;
            tocnt_q <= tocnt_d;
        end
    end

    assign hz.pc_en        = pc_en;
    assign hz.ifid_en      = ifid_en;
    assign hz.ifid_flush   = ifid_flush;
    assign hz.idex_en      = idex_en;
    assign hz.idex_flush   = idex_flush;
    assign hz.exmem_en     = exmem_en;
    assign hz.memwb_bubble = memwb_bubble;
    // HALT is only left through reset, so the fault flag is sticky
    assign hz.mem_fault    = (state_q == HALT);

`ifdef HAZARD_CTRL_PERF_CNT_EN
    hazard_perf_cnt u_perf_cnt (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall_inc    (!pc_en && (state_q != HALT)),
        .flush_inc    (ifid_flush),
        .stall_cycles (hz.stall_cycles),
        .flush_count  (hz.flush_count)
    );
`else
    assign hz.stall_cycles = 32'd0;
    assign hz.flush_count  = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Self-checking bench for hazard_ctrl: two configurations
//               (LOAD_BUBBLES=1/MEM_TIMEOUT=8, LOAD_BUBBLES=3/MEM_TIMEOUT=5)
//               driven with identical directed and random stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

`ifdef HAZARD_CTRL_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif
    localparam int LB_A = 1, MT_A = 8;
    localparam int LB_B = 3, MT_B = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_ctrl_if ifa ();
    hazard_ctrl_if ifb ();

    hazard_ctrl #(.LOAD_BUBBLES(LB_A), .MEM_TIMEOUT(MT_A)) dut_a (.clk(clk), .rst_n(rst_n), .hz(ifa));
    hazard_ctrl #(.LOAD_BUBBLES(LB_B), .MEM_TIMEOUT(MT_B)) dut_b (.clk(clk), .rst_n(rst_n), .hz(ifb));

    // Abstract model: bubbles still owed, wait length, halted flag, counters
    typedef struct {
        int          owed;
        int          wcnt;
        bit          waiting;
        bit          halted;
        logic [31:0] stalls;
        logic [31:0] flushes;
    } mstate_t;

    mstate_t ma, mb;
    int n_checks = 0;
    int n_fail   = 0;

    logic [4:0] s_rs1, s_rs2, s_rd;
    logic s_rs1_en, s_rs2_en, s_memrd, s_redir, s_req, s_ack, s_rstn;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic mstate_t mreset();
        mstate_t m;
        m.owed = 0; m.wcnt = 0; m.waiting = 1'b0; m.halted = 1'b0;
        m.stalls = '0; m.flushes = '0;
        return m;
    endfunction

    // One cycle of the reference behaviour for the current stimulus
    function automatic void model(input mstate_t cur, input int lb, input int mt,
                                  output logic [7:0] exp, output mstate_t nxt);
        bit pc, ie, ifl, de, dfl, xe, bub, flt, lu, mw;
        nxt = cur;
        pc = 1; ie = 1; ifl = 0; de = 1; dfl = 0; xe = 1; bub = 0; flt = cur.halted;
        lu = s_memrd && (s_rd != 5'd0) &&
             ((s_rs1_en && s_rs1 == s_rd) || (s_rs2_en && s_rs2 == s_rd));
        mw = s_req && !s_ack;
        if (!s_rstn) begin
            flt = 0;
            nxt = mreset();
        end else if (cur.halted) begin
            pc = 0; ie = 0; de = 0; xe = 0; bub = 1;
        end else if (mw) begin
            pc = 0; ie = 0; de = 0; xe = 0; bub = 1;
            nxt.wcnt    = cur.waiting ? cur.wcnt + 1 : 1;
            nxt.waiting = 1;
            if (cur.waiting && nxt.wcnt == mt) nxt.halted = 1;
        end else begin
            nxt.waiting = 0;
            nxt.wcnt    = 0;
            if (s_redir) begin
                ifl = 1; dfl = 1; nxt.owed = 0;
            end else if (cur.owed > 0) begin
                pc = 0; ie = 0; dfl = 1; nxt.owed = cur.owed - 1;
            end else if (lu) begin
                pc = 0; ie = 0; dfl = 1; nxt.owed = lb - 1;
            end
        end
        if (s_rstn && !cur.halted && !pc) nxt.stalls  = cur.stalls + 1;
        if (s_rstn && ifl)                nxt.flushes = cur.flushes + 1;
        exp = {pc, ie, ifl, de, dfl, xe, bub, flt};
    endfunction

    task automatic idle();
        s_rs1 = 0; s_rs2 = 0; s_rd = 0; s_rs1_en = 0; s_rs2_en = 0;
        s_memrd = 0; s_redir = 0; s_req = 0; s_ack = 0; s_rstn = 1;
    endtask

    task automatic load_use_rs1();
        idle();
        s_memrd = 1; s_rd = 5; s_rs1 = 5; s_rs1_en = 1;
    endtask

    // Apply stimulus, compare both DUTs with the model, advance one cycle
    task automatic step();
        logic [7:0] ea, eb;
        mstate_t na, nb;
        rst_n = s_rstn;
        ifa.id_rs1 = s_rs1; ifa.id_rs2 = s_rs2; ifa.id_rs1_en = s_rs1_en; ifa.id_rs2_en = s_rs2_en;
        ifa.idex_rd = s_rd; ifa.idex_memRead = s_memrd; ifa.ex_redirect = s_redir;
        ifa.mem_req = s_req; ifa.mem_ack = s_ack;
        ifb.id_rs1 = s_rs1; ifb.id_rs2 = s_rs2; ifb.id_rs1_en = s_rs1_en; ifb.id_rs2_en = s_rs2_en;
        ifb.idex_rd = s_rd; ifb.idex_memRead = s_memrd; ifb.ex_redirect = s_redir;
        ifb.mem_req = s_req; ifb.mem_ack = s_ack;
        #1;
        model(ma, LB_A, MT_A, ea, na);
        model(mb, LB_B, MT_B, eb, nb);
        chk("A.ctrl", {ifa.pc_en, ifa.ifid_en, ifa.ifid_flush, ifa.idex_en, ifa.idex_flush,
                       ifa.exmem_en, ifa.memwb_bubble, ifa.mem_fault}, ea);
        chk("B.ctrl", {ifb.pc_en, ifb.ifid_en, ifb.ifid_flush, ifb.idex_en, ifb.idex_flush,
                       ifb.exmem_en, ifb.memwb_bubble, ifb.mem_fault}, eb);
        chk("A.stall_cycles", ifa.stall_cycles, (PERF && s_rstn) ? ma.stalls  : 32'd0);
        chk("A.flush_count",  ifa.flush_count,  (PERF && s_rstn) ? ma.flushes : 32'd0);
        chk("B.stall_cycles", ifb.stall_cycles, (PERF && s_rstn) ? mb.stalls  : 32'd0);
        chk("B.flush_count",  ifb.flush_count,  (PERF && s_rstn) ? mb.flushes : 32'd0);
        ma = na;
        mb = nb;
        @(negedge clk);
    endtask

    initial begin
        int ack_pct;
        ma = mreset();
        mb = mreset();
        idle();
        s_rstn = 0;
        @(negedge clk);
        // Reset state, with a load-use pattern present that must be ignored
        load_use_rs1(); s_rstn = 0; step(); step();

        // Single load-use bubble (B owes three)
        idle(); step();
        load_use_rs1(); step();
        idle(); repeat (4) step();

        // x0 and non-read operands never stall
        idle(); s_memrd = 1; s_rd = 0; s_rs1 = 0; s_rs1_en = 1; step();
        idle(); s_memrd = 1; s_rd = 5; s_rs2 = 5; s_rs2_en = 0; s_rs1_en = 1; step();
        idle(); s_memrd = 1; s_rd = 7; s_rs2 = 7; s_rs2_en = 1; step();
        idle(); repeat (4) step();

        // Redirect on the second bubble cancels the rest
        load_use_rs1(); step();
        idle(); s_redir = 1; step();
        idle(); repeat (3) step();

        // Memory wait in the middle of a bubble sequence
        load_use_rs1(); step();
        idle(); s_req = 1; repeat (4) step();
        idle(); s_req = 1; s_ack = 1; step();
        idle(); repeat (4) step();

        // Timeout into HALT, then reset recovers
        idle(); s_req = 1; repeat (10) step();
        chk("A.fault_sticky", ifa.mem_fault, 1'b1);
        chk("B.fault_sticky", ifb.mem_fault, 1'b1);
        idle(); s_rstn = 0; step();
        chk("A.fault_cleared", ifa.mem_fault, 1'b0);
        idle(); step();

        // Two load-use stalls and one redirect on configuration A
        load_use_rs1(); step();
        idle(); repeat (4) step();
        load_use_rs1(); step();
        idle(); repeat (4) step();
        idle(); s_redir = 1; step();
        idle(); step();
        chk("A.perf_stall_total", ifa.stall_cycles, PERF ? 32'd2 : 32'd0);
        chk("A.perf_flush_total", ifa.flush_count,  PERF ? 32'd1 : 32'd0);

        // Randomized traffic
        ack_pct = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 64 == 0) begin
                case ($urandom_range(0, 3))
                    0: ack_pct = 0;
                    1: ack_pct = 30;
                    2: ack_pct = 70;
                    default: ack_pct = 100;
                endcase
            end
            s_rstn   = !(($urandom_range(0, 199) == 0) ||
                         (ma.halted && mb.halted && $urandom_range(0, 7) == 0));
            s_rs1    = 5'($urandom_range(0, 3));
            s_rs2    = 5'($urandom_range(0, 3));
            s_rd     = 5'($urandom_range(0, 3));
            s_rs1_en = 1'($urandom_range(0, 1));
            s_rs2_en = 1'($urandom_range(0, 1));
            s_memrd  = 1'($urandom_range(0, 1));
            s_redir  = ($urandom_range(0, 99) < 12);
            s_req    = ($urandom_range(0, 99) < 35);
            s_ack    = ($urandom_range(0, 99) < ack_pct);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage core.
- Drives per-stage register enables and flushes (PC, IF/ID, ID/EX, EX/MEM, MEM/WB bubble).
- Handles three hazards, with forwarding covering all remaining data hazards:
  - load-use stall with a programmable bubble count;
  - EX-stage branch/jump redirect flush;
  - data-memory wait, with a timeout that halts the core.

Parameters:
- LOAD_BUBBLES, 1: ID/EX bubbles inserted per load-use hazard (legal 1..15).
- MEM_TIMEOUT, 256: consecutive wait cycles before a memory fault (legal 2..65535).
- TO_W, $clog2(MEM_TIMEOUT+1): timeout counter width (derived; do not override).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- id_rs1  in  5  rs1 of instruction in ID
- id_rs2  in  5  rs2 of instruction in ID
- id_rs1_en  in  1  ID instruction actually reads rs1
- id_rs2_en  in  1  ID instruction actually reads rs2
- idex_rd  in  5  rd of instruction in EX
- idex_memRead  in  1  EX instruction is a load
- ex_redirect  in  1  EX resolved taken branch/jump
- mem_req  in  1  MEM-stage instruction accesses data memory
- mem_ack  in  1  data memory completes access this cycle
- pc_en  out  1  PC update enable
- ifid_en  out  1  IF/ID register enable
- ifid_flush  out  1  IF/ID becomes NOP
- idex_en  out  1  ID/EX register enable
- idex_flush  out  1  ID/EX becomes bubble
- exmem_en  out  1  EX/MEM register enable
- memwb_bubble  out  1  MEM/WB loads bubble (regWrite=0)
- mem_fault  out  1  sticky timeout flag
- stall_cycles  out  32  perf counter (see Optional Feature)
- flush_count  out  32  perf counter (see Optional Feature)

Behaviour:
- Definitions (combinational):
  - load_use = idex_memRead & idex_rd!=0 & ((id_rs1_en & id_rs1==idex_rd) | (id_rs2_en & id_rs2==idex_rd)).
  - mwait = mem_req & ~mem_ack.
- Default outputs: all enables 1, flushes 0, memwb_bubble 0.
- Priority within a cycle is mwait > ex_redirect > load_use/LOAD_STALL.
  - mwait: pc_en, ifid_en, idex_en, exmem_en = 0; memwb_bubble = 1; flushes 0. This applies in RUN, LOAD_STALL and MEM_WAIT alike.
  - ex_redirect (no mwait): ifid_flush = 1, idex_flush = 1, pc_en = 1; next state RUN, bubble counter cleared.
  - load_use in RUN, or state LOAD_STALL (no mwait, no redirect): pc_en = 0, ifid_en = 0, idex_flush = 1.
- FSM states: RUN, LOAD_STALL, MEM_WAIT, HALT. Reset state is RUN; all counters are 0.
- RUN:
  - mwait -> MEM_WAIT, timeout counter = 1, ret = RUN.
  - else if load_use and LOAD_BUBBLES>1 -> LOAD_STALL, bcnt = LOAD_BUBBLES-1.
  - else stay in RUN.
- LOAD_STALL:
  - mwait -> MEM_WAIT with ret = LOAD_STALL; bcnt is held.
  - else if ex_redirect -> RUN.
  - else bcnt decrements; at bcnt==1 -> RUN.
- MEM_WAIT:
  - mem_ack -> ret state. Outputs that cycle are computed as for ret with mwait=0 (the pipeline advances in the same cycle).
  - else counter increments; counter==MEM_TIMEOUT with ~mem_ack -> HALT, mem_fault = 1.
  - mem_req dropping without ack is treated as completion.
- HALT: all enables 0, memwb_bubble 1, flushes 0; stays until rst_n. mem_fault is sticky.
- Reset asserted mid-operation: immediate return to RUN. Enables are forced to defaults, mem_fault is cleared, counters are cleared.
- Register x0 never causes a hazard.
- Zero latency: every control output is combinational from the inputs plus registered state.

Optional Feature:
- Macro: HAZARD_CTRL_PERF_CNT_EN.
- When defined:
  - stall_cycles increments on every cycle with pc_en==0 outside HALT.
  - flush_count increments on every cycle with ifid_flush==1.
  - Both are 32-bit, wrap modulo 2^32, and reset to 0.
- When undefined: both outputs are tied to 0 and no counter flops are instantiated. Port list is unchanged.

Decomposition:
- Shared package holds:
  - state enum hz_state_t {RUN, LOAD_STALL, MEM_WAIT, HALT} (2 bits);
  - constant REG_X0 = 5'd0.
- One sub-module, hazard_perf_cnt: the two counters, instantiated only under the macro.
- Hazard compare and FSM stay in hazard_ctrl.

Test Plan:
- Load-use bubble, LOAD_BUBBLES=1: idex_memRead=1, idex_rd=5, id_rs1=5, id_rs1_en=1 -> exactly one cycle with pc_en=0, ifid_en=0, idex_flush=1; the next cycle is back to defaults.
- x0 and non-read cases:
  - idex_rd=0 with id_rs1=0 -> no stall.
  - id_rs2=5 with id_rs2_en=0 -> no stall.
- Multi-bubble, LOAD_BUBBLES=3: load-use pulse -> 3 consecutive stall cycles. If ex_redirect fires in the 2nd cycle, a flush occurs that cycle and state returns to RUN.
- Memory wait during LOAD_STALL: mem_req=1, mem_ack=0 for 4 cycles -> all enables 0 and memwb_bubble=1. Remaining bubbles then resume with unchanged bcnt.
- Timeout, MEM_TIMEOUT=8: mem_req=1 and no ack -> mem_fault=1 after the 8th wait cycle, HALT persists. rst_n low clears mem_fault and returns to RUN.
- Perf counters, macro defined: 2 load-use stalls + 1 redirect -> stall_cycles=2, flush_count=1. Macro undefined -> both read 0.
